// File: rtl/simt_mem_responder.sv
// simt_mem_responder: warp-request scratchpad responder, one active lane per cycle, single response beat.
// Define SIMT_MEM_COALESCE_EN to service every pending lane sharing the lowest lane's word in one cycle.
module simt_mem_responder #(
   parameter int WARP_SIZE  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [WARP_SIZE-1:0]             req_lane_valid,
   input  logic [WARP_SIZE*ADDR_WIDTH-1:0]  req_lane_addr,
   input  logic [WARP_SIZE*DATA_WIDTH-1:0]  req_lane_wdata,
   input  logic                             req_is_write,
   input  logic [1:0]                       req_size,
   output logic                             resp_valid,
   output logic [WARP_SIZE*DATA_WIDTH-1:0]  resp_rdata,
   output logic [WARP_SIZE-1:0]             resp_lane_valid,
   output logic [WARP_SIZE-1:0]             resp_lane_err
);
   localparam int IW = $clog2(MEM_DEPTH);
   localparam int LW = $clog2(WARP_SIZE);
   localparam logic [1:0] MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2;

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
   state_t state, state_nx;

   logic [WARP_SIZE-1:0]            pending, lane_ok, lane_err, svc, mis, pend_cap;
   logic [WARP_SIZE*ADDR_WIDTH-1:0] addr_q;
   logic [WARP_SIZE*DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic                            is_write_q;
   logic [1:0]                      size_q;
   logic [IW-1:0]                   widx [WARP_SIZE];
   logic [LW-1:0]                   sel;
   logic [31:0]                     mem [MEM_DEPTH];
   logic [31:0]                     rword, wword;
   logic                            unused_addr;

   function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
      return (sz == MEM_HALF && a[0]) || (sz == MEM_WORD && a != 2'd0);
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a, input logic [1:0] sz);
      return sz == MEM_BYTE ? {24'd0, w[{a, 3'd0} +: 8]} :
             sz == MEM_HALF ? {16'd0, w[{a[1], 4'd0} +: 16]} : w;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] a,
                                               input logic [31:0] d, input logic [1:0] sz);
      logic [3:0]  be;
      logic [31:0] sd, r;
      be = sz == MEM_BYTE ? 4'b0001 << a : sz == MEM_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
      sd = sz == MEM_BYTE ? {4{d[7:0]}} : sz == MEM_HALF ? {2{d[15:0]}} : d;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? sd[8*b +: 8] : w[8*b +: 8];
      return r;
   endfunction

   // Upper address bits only alias; word index wraps modulo the array depth.
   always_comb begin
      unused_addr = 1'b0;
      for (int i = 0; i < WARP_SIZE; i++) begin
         widx[i] = addr_q[i*ADDR_WIDTH+2 +: IW];
         unused_addr ^= ^addr_q[i*ADDR_WIDTH+IW+2 +: ADDR_WIDTH-IW-2];
         mis[i] = req_lane_valid[i] && misaligned(req_lane_addr[i*ADDR_WIDTH +: 2], req_size);
      end
      pend_cap = req_lane_valid & ~mis;
   end

   always_comb begin
      sel = '0;
      for (int i = WARP_SIZE-1; i >= 0; i--) if (pending[i]) sel = LW'(i);
      for (int i = 0; i < WARP_SIZE; i++)
`ifdef SIMT_MEM_COALESCE_EN
         svc[i] = pending[i] && widx[i] == widx[sel];
`else
         svc[i] = pending[i] && LW'(i) == sel;
`endif
      rword = mem[widx[sel]];
      wword = rword;
      for (int i = 0; i < WARP_SIZE; i++)
         if (svc[i]) wword = store_merge(wword, addr_q[i*ADDR_WIDTH +: 2], wdata_q[i*DATA_WIDTH +: DATA_WIDTH], size_q);
   end

   always_ff @(posedge clk)
      if (state == ACCESS && is_write_q) mem[widx[sel]] <= wword;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb
      state_nx = state == IDLE   ? (req_valid ? (|pend_cap ? ACCESS : RESPOND) : IDLE) :
                 state == ACCESS ? (~|(pending & ~svc) ? RESPOND : ACCESS) : IDLE;

   always_comb begin
      req_ready  = state == IDLE;
      resp_valid = state == RESPOND;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pending    <= '0;
         lane_ok    <= '0;
         lane_err   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         is_write_q <= 1'b0;
         size_q     <= '0;
      end else if (state == IDLE && req_valid) begin
         pending    <= pend_cap;
         lane_ok    <= '0;
         lane_err   <= mis;
         addr_q     <= req_lane_addr;
         wdata_q    <= req_lane_wdata;
         rdata_q    <= '0;
         is_write_q <= req_is_write;
         size_q     <= req_size;
      end else if (state == ACCESS) begin
         pending <= pending & ~svc;
         lane_ok <= lane_ok | svc;
         for (int i = 0; i < WARP_SIZE; i++)
            if (svc[i] && !is_write_q)
               rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= load_ext(rword, addr_q[i*ADDR_WIDTH +: 2], size_q);
      end

   assign resp_rdata      = rdata_q;
   assign resp_lane_valid = lane_ok;
   assign resp_lane_err   = lane_err;
endmodule

// File: tb/tb_simt_mem_responder.sv
// tb_simt_mem_responder: directed and random warp requests checked against a byte-array memory model.
module tb_simt_mem_responder;
   localparam int W = 32, DW = 32, AW = 32, D = 1024;

   logic clk = 0, rst_n = 0;
   logic req_valid = 0, req_ready, req_is_write = 0, resp_valid;
   logic [W-1:0] req_lane_valid = '0, resp_lane_valid, resp_lane_err;
   logic [W*AW-1:0] req_lane_addr = '0;
   logic [W*DW-1:0] req_lane_wdata = '0, resp_rdata;
   logic [1:0] req_size = '0;

   always #5 clk = ~clk;

   simt_mem_responder #(.WARP_SIZE(W), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_lane_valid(req_lane_valid), .req_lane_addr(req_lane_addr), .req_lane_wdata(req_lane_wdata),
      .req_is_write(req_is_write), .req_size(req_size), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_lane_valid(resp_lane_valid), .resp_lane_err(resp_lane_err));

   int vecs = 0, errs = 0;
   logic [7:0]  mb [4*D];
   logic [W-1:0] rm, exp_v, exp_err;
   logic [31:0] ra [W], rd [W], exp_rd [W];
   logic        rwr;
   logic [1:0]  rsz;
   int          exp_lat;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic wr, input logic [1:0] sz, input logic [W-1:0] m);
      rwr = wr; rsz = sz; rm = m;
      for (int i = 0; i < W; i++) begin ra[i] = 0; rd[i] = 0; end
   endtask

   // Reference: byte-addressed memory, lanes applied in ascending order.
   task automatic model();
      int n, nd, base, nb;
      bit dup;
      exp_v = '0; exp_err = '0; n = 0; nd = 0;
      nb = rsz == 0 ? 1 : rsz == 1 ? 2 : 4;
      for (int i = 0; i < W; i++) begin
         exp_rd[i] = 0;
         if (!rm[i]) continue;
         if ((rsz == 1 && ra[i] % 2 != 0) || (rsz == 2 && ra[i] % 4 != 0)) begin
            exp_err[i] = 1;
            continue;
         end
         exp_v[i] = 1; n++;
         base = int'(ra[i] % (4*D));
         dup = 0;
         for (int j = 0; j < i; j++) if (exp_v[j] && int'(ra[j] % (4*D)) / 4 == base / 4) dup = 1;
         if (!dup) nd++;
         for (int k = 0; k < nb; k++)
            if (rwr) mb[base+k] = rd[i][8*k +: 8];
            else exp_rd[i][8*k +: 8] = mb[base+k];
      end
`ifdef SIMT_MEM_COALESCE_EN
      exp_lat = nd + 1;
`else
      exp_lat = n + 1;
`endif
   endtask

   task automatic drive();
      @(negedge clk);
      check("ready_idle", req_ready, 1);
      for (int i = 0; i < W; i++) begin
         req_lane_addr[i*AW +: AW]  = ra[i];
         req_lane_wdata[i*DW +: DW] = rd[i];
      end
      req_lane_valid = rm; req_is_write = rwr; req_size = rsz; req_valid = 1;
      @(posedge clk);
      #1 req_valid = 0;
   endtask

   task automatic run_req(input string tag);
      int cyc;
      model();
      drive();
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!resp_valid && cyc < 200);
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_busy"}, req_ready, 0);
      check({tag, "_lv"}, resp_lane_valid, exp_v);
      check({tag, "_err"}, resp_lane_err, exp_err);
      for (int i = 0; i < W; i++)
         check($sformatf("%s_rd%0d", tag, i), resp_rdata[i*DW +: DW], exp_rd[i]);
      @(negedge clk);
      check({tag, "_pulse"}, resp_valid, 0);
      check({tag, "_ready_after"}, req_ready, 1);
      check({tag, "_hold"}, resp_lane_valid, exp_v);
   endtask

   initial begin
      int seen;
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_lv", resp_lane_valid, 0);
      check("rst_err", resp_lane_err, 0);
      check("rst_rdata", |resp_rdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      for (int p = 0; p < 2; p++) begin
         set_req(1, 2, '1);
         for (int i = 0; i < W; i++) begin ra[i] = 4*(i + 32*p); rd[i] = $urandom; end
         run_req("prefill");
      end

      set_req(1, 2, 32'hF);
      for (int i = 0; i < 4; i++) begin ra[i] = 4*i; rd[i] = 32'hA0 + i; end
      run_req("st4");
      set_req(0, 2, 32'hF);
      for (int i = 0; i < 4; i++) ra[i] = 4*i;
      run_req("ld4");
      check("ld4_const_l0", resp_rdata[31:0], 32'hA0);
      check("ld4_const_l3", resp_rdata[3*DW +: DW], 32'hA3);

      set_req(1, 2, 32'h1); ra[0] = 32'h100; rd[0] = 32'h11223344; run_req("stw100");
      set_req(1, 0, 32'h1); ra[0] = 32'h101; rd[0] = 32'hFFFFFF5A; run_req("sb101");
      set_req(0, 2, 32'h1); ra[0] = 32'h100; run_req("lw100");
      check("lw100_const", resp_rdata[31:0], 32'h11225A44);
      set_req(0, 1, 32'h1); ra[0] = 32'h102; run_req("lh102");
      check("lh102_const", resp_rdata[31:0], 32'h00001122);
      set_req(0, 0, 32'h1); ra[0] = 32'h103; run_req("lb103");
      check("lb103_const", resp_rdata[31:0], 32'h00000011);

      set_req(0, 2, 32'h3); ra[0] = 32'h2; ra[1] = 32'h4; run_req("misal");
      check("misal_err", resp_lane_err, 32'h1);
      check("misal_lv", resp_lane_valid, 32'h2);
      check("misal_rd0", resp_rdata[31:0], 0);

      set_req(0, 2, '0); run_req("empty");
      check("empty_lat_const", exp_lat, 1);

      set_req(0, 2, '1);
      for (int i = 0; i < W; i++) ra[i] = 32'h40;
      run_req("bcast");
      check("bcast_same", resp_rdata[31*DW +: DW], resp_rdata[31:0]);

      set_req(1, 2, 32'h88); ra[3] = 32'h80; ra[7] = 32'h80; rd[3] = 32'h33; rd[7] = 32'h77; run_req("dup");
      set_req(0, 2, 32'h1); ra[0] = 32'h80; run_req("ld80");
      check("ld80_const", resp_rdata[31:0], 32'h77);

      set_req(1, 2, 32'hFF);
      for (int i = 0; i < 8; i++) begin ra[i] = 32'h200 + 4*i; rd[i] = 32'h1000 + i; end
      run_req("pre200");
      set_req(1, 2, 32'hFF);
      for (int i = 0; i < 8; i++) begin ra[i] = 32'h200 + 4*i; rd[i] = 32'hC0DE0000 + i; end
      drive();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("midrst_ready", req_ready, 1);
      check("midrst_resp", resp_valid, 0);
      check("midrst_lv", resp_lane_valid, 0);
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) mb[32'h200 + 4*i + k] = rd[i][8*k +: 8];
      repeat (2) @(negedge clk);
      rst_n = 1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check("midrst_no_resp", seen, 0);
      set_req(0, 2, 32'hFF);
      for (int i = 0; i < 8; i++) ra[i] = 32'h200 + 4*i;
      run_req("ld200");
      check("ld200_l2_new", resp_rdata[2*DW +: DW], 32'hC0DE0002);
      check("ld200_l3_old", resp_rdata[3*DW +: DW], 32'h1003);

      set_req(1, 2, 32'h1); ra[0] = 4*D + 8; rd[0] = 32'hDEADBEEF; run_req("stwrap");
      set_req(0, 2, 32'h1); ra[0] = 32'h8; run_req("ldwrap");
      check("ldwrap_const", resp_rdata[31:0], 32'hDEADBEEF);

      for (int t = 0; t < 80; t++) begin
         int sel;
         bit hot;
         sel = $urandom_range(0, 9);
         set_req(1'($urandom), 2'($urandom_range(0, 2)), sel == 0 ? '0 : sel == 1 ? '1 : W'($urandom));
         hot = 1'($urandom);
         for (int i = 0; i < W; i++) begin
            int w, off;
            w = hot ? $urandom_range(0, 3) * 5 : $urandom_range(0, 63);
            off = $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) :
                  rsz == 0 ? $urandom_range(0, 3) : rsz == 1 ? 2 * $urandom_range(0, 1) : 0;
            ra[i] = ($urandom & 32'hFFFFF000) | 32'(w*4 + off);
            rd[i] = $urandom;
         end
         run_req($sformatf("rnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/simt_mem_responder.md
Name: simt_mem_responder

Overview:
- Responder end of the per-lane SIMT memory request interface; models a banked-free, single-port, word-organised scratchpad (shared memory).
- Accepts one warp request per handshake (up to WARP_SIZE lanes, load or store, byte/half/word size).
- Services active lanes serially in ascending lane order, then returns a single response beat carrying all lane data.
- Sits between the SIMT memory stage and on-chip shared memory; also used as the memory model in pipeline benches.

Parameters:
- WARP_SIZE, 32, number of lanes per request
- DATA_WIDTH, 32, lane data width (fixed 32; byte/half/word sizing assumes this)
- ADDR_WIDTH, 32, lane byte-address width
- MEM_DEPTH, 1024, scratchpad depth in 32-bit words (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept request
- req_lane_valid  in  WARP_SIZE  per-lane active mask
- req_lane_addr  in  WARP_SIZE*ADDR_WIDTH  per-lane byte address
- req_lane_wdata  in  WARP_SIZE*DATA_WIDTH  per-lane store data, right-aligned
- req_is_write  in  1  1=store, 0=load
- req_size  in  2  mem_size_t: MEM_BYTE, MEM_HALF, MEM_WORD
- resp_valid  out  1  response beat, single-cycle pulse
- resp_rdata  out  WARP_SIZE*DATA_WIDTH  per-lane load data, right-aligned, zero-extended
- resp_lane_valid  out  WARP_SIZE  lanes successfully serviced
- resp_lane_err  out  WARP_SIZE  lanes rejected as misaligned

Behaviour:
- States: IDLE, ACCESS, RESPOND. req_ready = (state==IDLE), combinational.
- Reset: state=IDLE, so req_ready=1. resp_valid=0; resp_rdata, resp_lane_valid, resp_lane_err = 0. Captured request cleared. Scratchpad contents are NOT reset.
- IDLE: on req_valid&&req_ready, capture mask, addresses, wdata, is_write and size.
  - Misaligned lanes are removed from the pending mask and set in the err register: half with addr[0]=1, word with addr[1:0]!=0.
  - Go to ACCESS if any pending lane remains, else go to RESPOND.
  - Read-data and lane_valid registers clear on capture.
- Word index = addr[log2(MEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*MEM_DEPTH bytes.
- ACCESS: each cycle, service the lowest-index pending lane, clear its pending bit, and set its lane_valid bit. Go to RESPOND the cycle the last pending bit clears.
  - Load byte: rdata = zero-extended byte at addr[1:0].
  - Load half: rdata = zero-extended half at addr[1].
  - Load word: rdata = full word.
  - Store: write wdata[7:0], [15:0] or [31:0] into the addressed byte lanes only; other bytes are unchanged.
  - Reads are combinational from the array in the same cycle.
- Duplicate store addresses: serviced in lane order, so the highest lane wins.
- RESPOND: resp_valid=1 for exactly one cycle, then return to IDLE.
  - resp_rdata, resp_lane_valid and resp_lane_err hold their values until the next capture.
  - Stores also produce a response; resp_rdata lanes are 0 for stores.
  - No backpressure: the initiator must be waiting.
- Latency: with N pending lanes, the request handshake is at edge T, ACCESS occupies N cycles, and resp_valid is high in cycle T+N+1. With N=0, resp_valid is high in cycle T+1.
- New requests cannot be accepted until the cycle after resp_valid, because req_ready=0 in ACCESS and RESPOND.
- Reset asserted mid-operation: immediate return to IDLE and no response. A store already issued to some lanes remains partially applied.
- Inactive lanes: resp_rdata=0, lane_valid=0, err=0.

Optional Feature:
- Macro: SIMT_MEM_COALESCE_EN.
- Defined: each ACCESS cycle services the lowest pending lane plus every other pending lane with the same word index.
  - Loads broadcast that word to all of those lanes.
  - Stores merge byte writes in ascending lane order, so the highest lane wins on overlapping bytes.
  - Latency becomes T + (number of distinct word indices) + 1.
- Not defined: one lane per cycle as above.
- Final memory and response contents are identical in both builds; only latency differs.

Test Plan:
- Store word, mask=0x0000000F, lane i addr=4*i, wdata=0xA0+i; then load the same addresses -> store resp_valid at T+5 with lane_valid=0xF; load resp_rdata lanes 0..3 = 0xA0..0xA3, and resp_valid at T+5 again.
- Byte store: addr 0x101 data 0x5A over a prior word 0x11223344 at 0x100; load word at 0x100 -> 0x11225A44. LH at 0x102 -> 0x00001122. LB at 0x103 -> 0x00000011.
- Misaligned: LW with lane0 addr=0x2, lane1 addr=0x4, mask=0x3 -> resp_lane_err=0x1, resp_lane_valid=0x2, resp_valid at T+2, lane0 rdata=0.
- Empty mask 0x0 -> resp_valid at T+1 with lane_valid=0 and err=0; req_ready low only in that one cycle.
- All 32 lanes load addr 0x40 -> resp_valid at T+33 without the macro and T+2 with SIMT_MEM_COALESCE_EN; rdata identical in all lanes.
- Duplicate store lanes 3 and 7 to 0x80 (0x33, 0x77), reset pulse mid-request on a separate request, address 4*MEM_DEPTH+8 -> read 0x80 = 0x77; after reset no resp_valid and req_ready=1; the wrapped address aliases 0x8.
